// File: rtl/instr_issue_unit.sv
// instr_issue_unit: small loadable instruction memory with a byte-addressed PC.
// Each instruction word is issued over a valid/ready handshake. The program runs
// until it reaches an all-zero end marker or the last memory word.
module instr_issue_unit #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4     // must equal $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    input  logic              start,
    input  logic              instr_ready,
    output logic [31:0]       instr_out,
    output logic              instr_valid,
    output logic [31:0]       pc_out,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;      // word index; byte PC is r_pc << 2
    logic [31:0]       r_instr;
    logic              r_valid;
    logic [31:0]       r_mem [DEPTH];

    logic              w_ctrl_open;  // IDLE or DONE: loads and start are honoured
    logic [31:0]       w_rd_word;

    assign w_ctrl_open = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_rd_word   = r_mem[r_pc];

    // Program memory: no reset, so a loaded program survives a reset
    always_ff @(posedge clk) begin
        if (load_en && w_ctrl_open)
            r_mem[load_addr] <= load_data;
    end

    // Sequencer: fetch one word, hold it until accepted, then step or stop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_instr <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_FETCH;
                        r_pc    <= '0;
                    end
                end
                S_FETCH: begin
                    r_instr <= w_rd_word;
                    if (w_rd_word == 32'h0) begin
                        r_state <= S_DONE;
                        r_valid <= 1'b0;
                    end else begin
                        r_state <= S_ISSUE;
                        r_valid <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (instr_ready) begin
                        r_valid <= 1'b0;
                        // Stop on the last word rather than wrapping back to 0
                        if (r_pc == LAST_WORD) begin
                            r_state <= S_DONE;
                        end else begin
                            r_pc    <= r_pc + 1'b1;
                            r_state <= S_FETCH;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign instr_out   = r_instr;
    assign instr_valid = r_valid;
    assign pc_out      = {{(30 - ADDR_W){1'b0}}, r_pc, 2'b00};
    assign busy        = (r_state == S_FETCH) || (r_state == S_ISSUE);
    assign done        = (r_state == S_DONE);

endmodule

// File: tb/tb_instr_issue_unit.sv
// Directed bench for instr_issue_unit. Inputs are driven 1ns after the rising
// edge, and outputs are sampled at that same point.
module tb_instr_issue_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_en = 1'b0;
    logic [3:0]  load_addr = '0;
    logic [31:0] load_data = '0;
    logic        start = 1'b0;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    logic [31:0] c_instr [32];
    logic [31:0] c_pc    [32];
    int          c_cyc   [32];
    int          c_n;
    int          c_done;

    instr_issue_unit #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .instr_ready(instr_ready),
        .instr_out(instr_out), .instr_valid(instr_valid), .pc_out(pc_out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic load_basic();
        load(4'd0, 32'h002082B3);
        load(4'd1, 32'h402082B3);
        load(4'd2, 32'h00C5F533);
        load(4'd3, 32'h00000000);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Record every accepted handshake until done or the budget runs out
    task automatic collect(input int budget);
        c_n = 0; c_done = -1;
        for (int c = 1; c <= budget; c++) begin
            tick();
            if (instr_valid && instr_ready) begin
                if (c_n < 32) begin
                    c_instr[c_n] = instr_out; c_pc[c_n] = pc_out; c_cyc[c_n] = c;
                end
                c_n++;
            end
            if (done) begin
                c_done = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", pc_out); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_basic();
        logic [31:0] exp_i [3];
        exp_i[0] = 32'h002082B3; exp_i[1] = 32'h402082B3; exp_i[2] = 32'h00C5F533;
        load_basic();
        instr_ready = 1'b1;
        pulse_start();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_fetch_busy got=%b exp=1", busy); end
        collect(40);
        total++; if (c_n !== 3) begin bad++; $display("FAIL basic_count got=%0d exp=3", c_n); end
        for (int k = 0; k < 3 && k < c_n; k++) begin
            total++; if (c_instr[k] !== exp_i[k]) begin bad++; $display("FAIL basic_instr%0d got=%h exp=%h", k, c_instr[k], exp_i[k]); end
            total++; if (c_pc[k] !== 32'(4 * k)) begin bad++; $display("FAIL basic_pc%0d got=%0d exp=%0d", k, c_pc[k], 4 * k); end
            total++; if (c_cyc[k] !== 1 + 2 * k) begin bad++; $display("FAIL basic_cycle%0d got=%0d exp=%0d", k, c_cyc[k], 1 + 2 * k); end
        end
        total++; if (c_done !== 7) begin bad++; $display("FAIL basic_done_cycle got=%0d exp=7", c_done); end
        total++; if (pc_out !== 32'd12) begin bad++; $display("FAIL basic_done_pc got=%0d exp=12", pc_out); end
        total++; if (busy !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL basic_done_idle busy=%b valid=%b exp=0,0", busy, instr_valid); end
    endtask

    task automatic test_backpressure();
        instr_ready = 1'b0;
        pulse_start();
        tick();
        for (int i = 0; i < 5; i++) begin
            total++; if (instr_valid !== 1'b1 || instr_out !== 32'h002082B3 || pc_out !== 32'h0) begin
                bad++; $display("FAIL bp_hold%0d valid=%b instr=%h pc=%0d exp=1,002082b3,0", i, instr_valid, instr_out, pc_out);
            end
            tick();
        end
        instr_ready = 1'b1;
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL bp_still_valid got=%b exp=1", instr_valid); end
        tick();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL bp_accepted got=%b exp=0", instr_valid); end
        collect(20);
        total++; if (c_n !== 2) begin bad++; $display("FAIL bp_count got=%0d exp=2", c_n); end
        total++; if (c_n > 0 && (c_instr[0] !== 32'h402082B3 || c_pc[0] !== 32'd4)) begin bad++; $display("FAIL bp_second got=%h@%0d exp=402082b3@4", c_instr[0], c_pc[0]); end
        total++; if (c_n > 1 && (c_instr[1] !== 32'h00C5F533 || c_pc[1] !== 32'd8)) begin bad++; $display("FAIL bp_third got=%h@%0d exp=00c5f533@8", c_instr[1], c_pc[1]); end
        total++; if (c_done !== 5) begin bad++; $display("FAIL bp_done_cycle got=%0d exp=5", c_done); end
    endtask

    task automatic test_ignored();
        instr_ready = 1'b0;
        pulse_start();
        tick();
        start = 1'b1; load_en = 1'b1; load_addr = 4'd1; load_data = 32'hFFFFFFFF;
        tick();
        start = 1'b0; load_en = 1'b0;
        total++; if (instr_valid !== 1'b1 || instr_out !== 32'h002082B3 || pc_out !== 32'h0) begin
            bad++; $display("FAIL ign_hold valid=%b instr=%h pc=%0d exp=1,002082b3,0", instr_valid, instr_out, pc_out);
        end
        instr_ready = 1'b1;
        collect(20);
        total++; if (c_n !== 2) begin bad++; $display("FAIL ign_count got=%0d exp=2", c_n); end
        total++; if (c_n > 0 && c_instr[0] !== 32'h402082B3) begin bad++; $display("FAIL ign_mem1 got=%h exp=402082b3", c_instr[0]); end
        total++; if (c_done !== 6) begin bad++; $display("FAIL ign_done_cycle got=%0d exp=6", c_done); end
    endtask

    task automatic test_full_memory();
        for (int i = 0; i < 16; i++) load(4'(i), 32'h10000000 + 32'(i));
        instr_ready = 1'b1;
        pulse_start();
        collect(60);
        total++; if (c_n !== 16) begin bad++; $display("FAIL full_count got=%0d exp=16", c_n); end
        for (int k = 0; k < 16 && k < c_n; k++) begin
            total++; if (c_instr[k] !== 32'h10000000 + 32'(k) || c_pc[k] !== 32'(4 * k)) begin
                bad++; $display("FAIL full_word%0d got=%h@%0d exp=%h@%0d", k, c_instr[k], c_pc[k], 32'h10000000 + 32'(k), 4 * k);
            end
        end
        total++; if (c_done !== 32) begin bad++; $display("FAIL full_done_cycle got=%0d exp=32", c_done); end
        repeat (3) tick();
        total++; if (pc_out !== 32'd60 || instr_valid !== 1'b0 || done !== 1'b1) begin
            bad++; $display("FAIL full_no_wrap pc=%0d valid=%b done=%b exp=60,0,1", pc_out, instr_valid, done);
        end
    endtask

    task automatic test_restart();
        load(4'd0, 32'h00000000);
        pulse_start();
        total++; if (done !== 1'b0 || busy !== 1'b1 || pc_out !== 32'h0 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL restart_fetch done=%b busy=%b pc=%0d valid=%b exp=0,1,0,0", done, busy, pc_out, instr_valid);
        end
        tick();
        total++; if (done !== 1'b1 || instr_valid !== 1'b0 || pc_out !== 32'h0) begin
            bad++; $display("FAIL restart_done done=%b valid=%b pc=%0d exp=1,0,0", done, instr_valid, pc_out);
        end
    endtask

    task automatic test_mid_reset();
        load(4'd0, 32'h002082B3);
        instr_ready = 1'b1;
        pulse_start();
        tick();
        tick();
        instr_ready = 1'b0;
        tick();
        total++; if (instr_valid !== 1'b1 || pc_out !== 32'd4) begin
            bad++; $display("FAIL midrst_pre valid=%b pc=%0d exp=1,4", instr_valid, pc_out);
        end
        rst = 1'b1;
        #1;
        total++; if (instr_valid !== 1'b0 || pc_out !== 32'h0 || instr_out !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL midrst_async valid=%b pc=%0d instr=%h busy=%b done=%b exp=0,0,0,0,0", instr_valid, pc_out, instr_out, busy, done);
        end
        tick();
        rst = 1'b0;
        tick();
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL midrst_idle busy=%b done=%b exp=0,0", busy, done); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_ignored();
        test_full_memory();
        test_restart();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_issue_unit.md
Name: instr_issue_unit

Overview:
- Instruction source for the R-type execution datapath (prog_counter).
- Holds a small loadable instruction memory, steps a byte-addressed PC, and presents one 32-bit instruction at a time over a valid/ready handshake.
- Replaces hand-driven Instruction stimulus: programs are loaded once, then run autonomously until an end-of-program marker or memory end.

Parameters:
- DEPTH, 16, number of 32-bit instruction words in local memory.
- ADDR_W, 4, word-address width; must equal clog2(DEPTH).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- load_en  input  1  write load_data into memory at load_addr; honoured only in IDLE or DONE.
- load_addr  input  ADDR_W  word address for load.
- load_data  input  32  instruction word to store.
- start  input  1  begin execution from PC=0; honoured only in IDLE or DONE.
- instr_ready  input  1  datapath accepts instr_out this cycle.
- instr_out  output  32  current instruction, registered.
- instr_valid  output  1  instr_out holds a valid instruction.
- pc_out  output  32  byte address of the instruction in instr_out / being fetched.
- busy  output  1  high in FETCH or ISSUE.
- done  output  1  high in DONE.

Behaviour:
- Reset (async, any time, including mid-program): state=IDLE, pc_out=0, instr_out=0, instr_valid=0, busy=0, done=0. Memory contents are not cleared.
- States: IDLE, FETCH, ISSUE, DONE.
- IDLE: load_en writes mem[load_addr] on the clock edge. start moves to FETCH with pc=0. If load_en and start are both high, the write completes and FETCH reads the new data on the next cycle.
- FETCH (1 cycle):
  - Register mem[pc[ADDR_W+1:2]] into instr_out.
  - If the word is 32'h00000000 (end marker), go to DONE; instr_valid stays 0.
  - Otherwise go to ISSUE and set instr_valid=1.
- ISSUE:
  - instr_valid=1. instr_out and pc_out are held stable while instr_ready=0, for any number of cycles.
  - On instr_ready=1: instr_valid drops next cycle.
  - If pc == 4*(DEPTH-1), go to DONE with pc unchanged.
  - Otherwise pc += 4 and go to FETCH.
  - Throughput: 1 instruction per 2 cycles when instr_ready is held high.
- DONE: done=1, busy=0, instr_valid=0, pc_out holds the last issued or marker address. load_en is permitted. start returns to FETCH with pc=0 and done=0 on the next cycle.
- Ignored inputs:
  - start in FETCH or ISSUE.
  - load_en in FETCH or ISSUE (no write occurs).
  - instr_ready outside ISSUE.
- pc_out[1:0] is always 2'b00. The PC never wraps past the last word; the block stops in DONE instead.

Test Plan:
- Reset/idle: hold rst=1 for 3 cycles, then release -> instr_valid=0, pc_out=0, done=0, busy=0. Assert rst mid-ISSUE -> all outputs return to reset values asynchronously, before the next clock edge.
- Basic run:
  - Load mem[0]=0x002082B3 (add x5,x1,x2), mem[1]=0x402082B3 (sub), mem[2]=0x00C5F533 (and x10,x11,x12), mem[3]=0x00000000.
  - start with ready held high -> valid pulses show 0x002082B3 @pc 0, 0x402082B3 @pc 4, 0x00C5F533 @pc 8, each valid for exactly 1 cycle, 2 cycles apart.
  - done rises when the marker at pc 12 is fetched.
- Backpressure: same program, instr_ready=0 for 5 cycles during the first ISSUE -> instr_out stays 0x002082B3, pc_out=0, valid=1 throughout. Acceptance happens on the ready cycle and the sequence continues unchanged.
- Full memory: fill all 16 words non-zero -> 16 instructions issued, last at pc_out=60, then DONE. No wrap to pc 0.
- Ignored controls: pulse start and load_en(addr 1, data 0xFFFFFFFF) during ISSUE -> no restart, mem[1] unchanged, second issued word still 0x402082B3.
- Restart: from DONE, load mem[0]=0x00000000, then start -> FETCH then immediately DONE, with no instr_valid pulse and pc_out=0.
